core_fetch: RTL and testbench

CORE_FETCH -- requirements
Module: core_fetch

---
 rtl/rv_pkg.sv | 7 +
 rtl/core_fetch_if.sv | 34 +++
 rtl/core_fetch_fifo.sv | 69 ++++++
 rtl/core_fetch.sv | 124 ++++++++++++
 tb/tb_core_fetch.sv | 315 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/rv_pkg.sv
// Shared RISC-V core types used across the core slice.
package rv;

    typedef logic [31:0] addr_t;
    typedef logic [31:0] instr_t;

endpackage

// File: rtl/core_fetch_if.sv
// Interfaces between fetch and its neighbours: the branch-unit redirect
// port (f_if) and the fetch-to-decode handoff (d_if).
//
// d_if handshake: a transfer happens on a rising edge where valid and ready
// are both high. While valid is high, pc and ir hold the head entry and do
// not change until that transfer (or a redirect flush) happens. The
// producer never waits for ready before raising valid. ready may be raised
// at any time and may depend on valid.

interface f_if;
    import rv::*;

    addr_t pc_new;
    logic  pc_load;

    // Fetch side: follows the redirect.
    modport master (input pc_new, input pc_load);
    // Branch-unit side: issues the redirect.
    modport slave  (output pc_new, output pc_load);
endinterface

interface d_if;
    import rv::*;

    logic   valid;
    addr_t  pc;
    instr_t ir;
    logic   ready;

    // Fetch side: produces instructions.
    modport slave  (output valid, output pc, output ir, input ready);
    // Decode side: consumes instructions.
    modport master (input valid, input pc, input ir, output ready);
endinterface

// File: rtl/core_fetch_fifo.sv
// Small circular instruction buffer with synchronous clear.
// Pop on empty and push on full (without a same-cycle pop) are ignored.
module core_fetch_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 64
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         push,
    input  logic [WIDTH-1:0]             wdata,
    input  logic                         pop,
    input  logic                         clear,
    output logic [WIDTH-1:0]             rdata,
    output logic                         full,
    output logic                         empty,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             push_ok, pop_ok;

    assign empty   = (count_q == '0);
    assign full    = (count_q == CW'(DEPTH));
    assign pop_ok  = pop && !empty;
    assign push_ok = push && (!full || pop_ok);
    assign rdata   = mem_q[rd_ptr_q];
    assign count   = count_q;

    // Next pointer/occupancy; clear wins over any push or pop.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (clear) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push_ok) wr_ptr_d = wr_ptr_q + AW'(1);
            if (pop_ok)  rd_ptr_d = rd_ptr_q + AW'(1);
            count_d = count_q + CW'(push_ok) - CW'(pop_ok);
        end
    end

    // Pointer and occupancy registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Entry storage; contents are don't-care until written, so no reset.
    always_ff @(posedge clk) begin
        if (push_ok && !clear) mem_q[wr_ptr_q] <= wdata;
    end

endmodule

// File: rtl/core_fetch.sv
// Instruction fetch: issues sequential word fetches to instruction memory,
// buffers in-order responses with their PC, and hands them to decode.
// A redirect flushes the buffer and discards responses still owed for the
// old path while fetching of the new path continues.
module core_fetch
    import rv::*;
#(
    parameter addr_t RESET_PC = 32'h0000_0000,
    parameter int    DEPTH    = 4
) (
    input  logic   clk,
    input  logic   rst_n,
    f_if.master    f,
    d_if.slave     d,
    output logic   imem_req_valid,
    input  logic   imem_req_ready,
    output addr_t  imem_addr,
    input  logic   imem_rsp_valid,
    input  instr_t imem_rdata
);

    localparam int    CW       = $clog2(DEPTH+1);
    localparam addr_t START_PC = RESET_PC & 32'hFFFF_FFFC;

    typedef struct packed {
        addr_t  pc;
        instr_t ir;
    } entry_t;

    addr_t         pc_q, pc_d;
    // PC of the next response that will be kept; responses return in order
    // and the kept ones are consecutive words from the last redirect target.
    addr_t         rsp_pc_q, rsp_pc_d;
    logic [CW-1:0] inflight_q, inflight_d;
    logic [CW-1:0] drop_q, drop_d;

    logic [CW-1:0] fifo_count;
    logic          fifo_full, fifo_empty;
    entry_t        fifo_wdata, fifo_rdata;
    logic          fifo_push, fifo_pop;

    logic          req_fire;
    logic          rsp_live, rsp_stale;
    logic [CW+1:0] used_credits;
    addr_t         redirect_pc;

    // Every outstanding response (kept or stale) and every buffered entry
    // holds one credit, so the buffer can never overflow.
    assign used_credits   = {2'b00, inflight_q} + {2'b00, drop_q} + {2'b00, fifo_count};
    assign imem_req_valid = rst_n && !f.pc_load && (used_credits < (CW+2)'(DEPTH));
    assign imem_addr      = pc_q;
    assign req_fire       = imem_req_valid && imem_req_ready;

    assign rsp_stale   = imem_rsp_valid && (drop_q != '0);
    assign rsp_live    = imem_rsp_valid && (drop_q == '0);
    assign redirect_pc = f.pc_new & 32'hFFFF_FFFC;

    assign fifo_wdata = '{pc: rsp_pc_q, ir: imem_rdata};
    assign fifo_push  = rsp_live && !f.pc_load && (!fifo_full || fifo_pop);
    assign fifo_pop   = d.valid && d.ready;

    assign d.valid = !fifo_empty;
    assign d.pc    = fifo_rdata.pc;
    assign d.ir    = fifo_rdata.ir;

    core_fetch_fifo #(
        .DEPTH (DEPTH),
        .WIDTH ($bits(entry_t))
    ) u_buf (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (fifo_push),
        .wdata (fifo_wdata),
        .pop   (fifo_pop),
        .clear (f.pc_load),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    // PC and credit bookkeeping; a redirect is applied last so that the
    // drop count includes this cycle's accept and response.
    always_comb begin
        pc_d       = pc_q;
        rsp_pc_d   = rsp_pc_q;
        inflight_d = inflight_q;
        drop_d     = drop_q;

        if (req_fire) begin
            pc_d       = pc_q + 32'd4;
            inflight_d = inflight_d + CW'(1);
        end
        if (rsp_live) begin
            inflight_d = inflight_d - CW'(1);
            rsp_pc_d   = rsp_pc_q + 32'd4;
        end
        if (rsp_stale) begin
            drop_d = drop_d - CW'(1);
        end
        if (f.pc_load) begin
            pc_d       = redirect_pc;
            rsp_pc_d   = redirect_pc;
            drop_d     = drop_d + inflight_d;
            inflight_d = '0;
        end
    end

    // Fetch state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q       <= START_PC;
            rsp_pc_q   <= START_PC;
            inflight_q <= '0;
            drop_q     <= '0;
        end else begin
            pc_q       <= pc_d;
            rsp_pc_q   <= rsp_pc_d;
            inflight_q <= inflight_d;
            drop_q     <= drop_d;
        end
    end

endmodule

// File: tb/tb_core_fetch.sv
// Bench for core_fetch: randomized memory/decode/redirect traffic checked
// every cycle against a transaction-level model (epoch-tagged requests).
module tb_core_fetch;
    import rv::*;

    localparam addr_t RST_PC = 32'h0000_0100;
    localparam int    DEPTH  = 4;

    typedef struct {
        addr_t addr;
        int    epoch;
        int    due;
    } mreq_t;

    logic   clk = 1'b0;
    logic   rst_n = 1'b0;
    logic   imem_req_valid, imem_req_ready, imem_rsp_valid;
    addr_t  imem_addr;
    instr_t imem_rdata;

    f_if fi ();
    d_if di ();

    core_fetch #(
        .RESET_PC (RST_PC),
        .DEPTH    (DEPTH)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .f              (fi),
        .d              (di),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_addr      (imem_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rdata     (imem_rdata)
    );

    // Clock
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state
    mreq_t       mem_q[$];
    logic [63:0] exp_q[$];
    addr_t       m_pc;
    int          epoch;
    int          cyc = 0;

    // Stimulus knobs
    int    p_rr, p_dr, p_rsp, p_load, lat_min, lat_max;
    logic  force_load, load_on_rsp;
    addr_t force_pc_new;

    // Events observed on the DUT in the last step
    logic  ev_fire, ev_pop, ev_load;
    addr_t ev_fire_addr, ev_pop_pc;

    function automatic instr_t mem_word(input addr_t a);
        return {a[15:0], a[31:16]} ^ 32'hC0DE_5A5A;
    endfunction

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic model_reset();
        mem_q.delete();
        exp_q.delete();
        m_pc  = RST_PC;
        epoch = 0;
    endtask

    task automatic set_knobs(input int rr, input int dr, input int rs, input int ld,
                             input int lmin, input int lmax);
        p_rr = rr; p_dr = dr; p_rsp = rs; p_load = ld; lat_min = lmin; lat_max = lmax;
    endtask

    // One clock cycle: called just after a falling edge, returns at the next one.
    task automatic step();
        mreq_t       h;
        logic        rsp, load, exp_rv, fire, pop;
        addr_t       tgt;
        int          lat;
        rsp = 1'b0;
        if (mem_q.size() > 0) begin
            if (mem_q[0].due <= cyc && $urandom_range(99) < p_rsp) rsp = 1'b1;
        end
        imem_rsp_valid = rsp;
        imem_rdata     = '0;
        if (rsp) imem_rdata = mem_word(mem_q[0].addr);
        imem_req_ready = ($urandom_range(99) < p_rr);
        di.ready       = ($urandom_range(99) < p_dr);
        load = 1'b0;
        tgt  = '0;
        if (force_load) begin
            if (!load_on_rsp || rsp) begin
                load = 1'b1;
                tgt = force_pc_new;
                force_load = 1'b0;
            end
        end else if ($urandom_range(99) < p_load) begin
            load = 1'b1;
            tgt = $urandom;
            if ($urandom_range(3) == 0) tgt = 32'hFFFF_FFF0 | ($urandom & 32'hF);
        end
        fi.pc_load = load;
        fi.pc_new  = tgt;
        #1;
        exp_rv = !load && (mem_q.size() + exp_q.size() < DEPTH);
        check("req_valid", imem_req_valid, exp_rv);
        check("imem_addr", imem_addr, m_pc);
        check("d_valid", di.valid, exp_q.size() > 0);
        if (exp_q.size() > 0) check("d_pc_ir", {di.pc, di.ir}, exp_q[0]);
        ev_fire      = imem_req_valid && imem_req_ready;
        ev_fire_addr = imem_addr;
        ev_pop       = di.valid && di.ready;
        ev_pop_pc    = di.pc;
        ev_load      = load;
        fire = exp_rv && imem_req_ready;
        pop  = (exp_q.size() > 0) && di.ready;
        @(posedge clk);
        if (pop) void'(exp_q.pop_front());
        if (rsp) begin
            h = mem_q.pop_front();
            if (!load && h.epoch == epoch) exp_q.push_back({h.addr, mem_word(h.addr)});
        end
        if (fire) begin
            lat = $urandom_range(lat_max, lat_min);
            h.addr  = m_pc;
            h.epoch = epoch;
            h.due   = cyc + 1 + lat;
            mem_q.push_back(h);
            m_pc = m_pc + 32'd4;
        end
        if (load) begin
            epoch++;
            exp_q.delete();
            m_pc = {tgt[31:2], 2'b00};
        end
        cyc++;
        @(negedge clk);
    endtask

    task automatic drain();
        set_knobs(0, 100, 100, 0, 0, 0);
        for (int i = 0; i < 60 && (mem_q.size() + exp_q.size()) > 0; i++) step();
        check("drain_idle", di.valid, 1'b0);
    endtask

    task automatic wait_fire(input string tag, output addr_t a);
        logic found = 1'b0;
        a = '0;
        for (int i = 0; i < 40 && !found; i++) begin
            step();
            if (ev_fire) begin
                found = 1'b1;
                a = ev_fire_addr;
            end
        end
        check(tag, found, 1'b1);
    endtask

    task automatic wait_pop(input string tag, output addr_t pc);
        logic found = 1'b0;
        pc = '0;
        for (int i = 0; i < 40 && !found; i++) begin
            step();
            if (ev_pop) begin
                found = 1'b1;
                pc = ev_pop_pc;
            end
        end
        check(tag, found, 1'b1);
    endtask

    // Watchdog
    initial begin
        #500000;
        n_tests++;
        n_fail++;
        $display("FAIL watchdog: got timeout expected completion");
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    // Main sequence
    initial begin
        addr_t a;
        addr_t pop_pc[$];
        int    pop_cyc[$];
        fi.pc_load = 1'b0;
        fi.pc_new  = '0;
        di.ready   = 1'b0;
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b0;
        imem_rdata     = '0;
        force_load  = 1'b0;
        load_on_rsp = 1'b0;
        force_pc_new = '0;
        set_knobs(100, 100, 100, 0, 0, 0);
        model_reset();

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_req_valid", imem_req_valid, 1'b0);
        check("rst_d_valid", di.valid, 1'b0);
        check("rst_addr", imem_addr, RST_PC);

        // Streaming with latency 1 and decode always ready
        rst_n = 1'b1;
        step();
        check("first_req_fire", ev_fire, 1'b1);
        check("first_req_addr", ev_fire_addr, RST_PC);
        for (int i = 0; i < 7; i++) begin
            step();
            if (ev_pop) begin
                pop_pc.push_back(ev_pop_pc);
                pop_cyc.push_back(cyc);
            end
        end
        check("stream_pops", pop_pc.size() >= 3, 1'b1);
        if (pop_pc.size() >= 3) begin
            for (int k = 0; k < 3; k++) begin
                check("stream_pc", pop_pc[k], RST_PC + 32'(4 * k));
                check("stream_gap", 32'(pop_cyc[k] - pop_cyc[0]), 32'(k));
            end
        end

        // Backpressure: decode stalls for 10 cycles
        set_knobs(100, 0, 100, 0, 0, 0);
        repeat (10) step();
        check("bp_req_low", imem_req_valid, 1'b0);
        check("bp_d_valid", di.valid, 1'b1);
        set_knobs(100, 100, 100, 0, 0, 1);
        repeat (20) step();

        // Redirect with two requests in flight
        drain();
        set_knobs(100, 100, 100, 0, 4, 4);
        repeat (2) step();
        force_pc_new = 32'h0000_2003;
        load_on_rsp  = 1'b0;
        force_load   = 1'b1;
        step();
        check("redir_taken", ev_load, 1'b1);
        set_knobs(100, 100, 100, 0, 0, 0);
        wait_pop("redir_pop_seen", a);
        check("redir_first_pc", a, 32'h0000_2000);

        // Redirect coincident with a response, three outstanding
        drain();
        set_knobs(100, 100, 100, 0, 2, 2);
        repeat (3) step();
        force_pc_new = 32'h0000_2001;
        load_on_rsp  = 1'b1;
        force_load   = 1'b1;
        for (int i = 0; i < 10 && force_load; i++) step();
        check("sim_load_taken", force_load, 1'b0);
        set_knobs(100, 100, 100, 0, 0, 0);
        wait_fire("sim_fire_seen", a);
        check("sim_first_req", a, 32'h0000_2000);
        wait_pop("sim_pop_seen", a);
        check("sim_first_pc", a, 32'h0000_2000);

        // Address wrap
        drain();
        set_knobs(100, 100, 100, 0, 0, 0);
        force_pc_new = 32'hFFFF_FFFC;
        load_on_rsp  = 1'b0;
        force_load   = 1'b1;
        step();
        wait_fire("wrap_fire0_seen", a);
        check("wrap_req0", a, 32'hFFFF_FFFC);
        wait_fire("wrap_fire1_seen", a);
        check("wrap_req1", a, 32'h0000_0000);
        repeat (10) step();

        // Randomized traffic
        for (int blk = 0; blk < 15; blk++) begin
            set_knobs($urandom_range(100, 30), $urandom_range(100, 20), $urandom_range(100, 40),
                      $urandom_range(8, 0), 0, $urandom_range(4, 0));
            repeat (100) step();
        end

        // Asynchronous reset mid-stream
        set_knobs(100, 100, 100, 0, 0, 0);
        repeat (6) step();
        #2;
        rst_n = 1'b0;
        imem_rsp_valid = 1'b0;
        #1;
        check("arst_req_valid", imem_req_valid, 1'b0);
        check("arst_d_valid", di.valid, 1'b0);
        model_reset();
        @(negedge clk);
        @(negedge clk);
        check("arst_addr", imem_addr, RST_PC);
        rst_n = 1'b1;
        step();
        check("arst_first_fire", ev_fire, 1'b1);
        check("arst_first_addr", ev_fire_addr, RST_PC);
        repeat (20) step();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
